// File: rtl/fp_norm_if.sv
// Operand-in / result-out handshake bundle for the FP mantissa normaliser.
interface fp_norm_if #(
  parameter int MW = 24,
  parameter int EW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_exp;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic [4:0]    out_shift;
  logic          out_zero;
  logic          out_denorm;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_denorm
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_denorm
  );
endinterface

// File: rtl/fp_norm_seq.sv
// Multi-cycle mantissa normaliser: shifts left up to STEP bits per cycle until the
// hidden bit is set, flooring the exponent at zero and flagging zero/denormal results.
module fp_norm_seq #(
  parameter int MW   = 24,
  parameter int EW   = 8,
  parameter int STEP = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      abort,
  output logic      busy,
  fp_norm_if.slave  bus
);
  // state | meaning
  // IDLE  | waiting for an operand, in_ready high
  // SHIFT | one normalisation decision per cycle
  // DONE  | result presented, held until out_ready or abort
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] mant_q, mant_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [4:0]    shift_q, shift_d;
  logic          zero_q, zero_d;
  logic          denorm_q, denorm_d;
  int            k_w;

  function automatic logic [5:0] lzc(input logic [MW-1:0] m);
    logic [5:0] n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n = n + 6'd1;
      end
    end
    return n;
  endfunction

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    shift_d  = shift_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;
    k_w      = 0;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            mant_d   = bus.in_mant;
            exp_d    = bus.in_exp;
            shift_d  = '0;
            zero_d   = 1'b0;
            denorm_d = 1'b0;
            state_d  = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (mant_q == '0) begin
            exp_d   = '0;
            zero_d  = 1'b1;
            state_d = S_DONE;
          end else if (mant_q[MW-1]) begin
            state_d = S_DONE;
          end else if (exp_q <= EW'(1)) begin
            exp_d    = '0;
            denorm_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            // exp_q >= 2 here, so capping k at exp-1 keeps the exponent >= 1
            k_w = int'(lzc(mant_q));
            if (k_w > STEP)             k_w = STEP;
            if (k_w > int'(exp_q) - 1)  k_w = int'(exp_q) - 1;
            mant_d  = mant_q << k_w;
            exp_d   = exp_q - EW'(k_w);
            shift_d = shift_q + 5'(k_w);
          end
        end
        S_DONE: begin
          if (bus.out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      shift_q  <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      shift_q  <= shift_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign busy           = (state_q != S_IDLE);
  assign bus.out_mant   = mant_q;
  assign bus.out_exp    = exp_q;
  assign bus.out_shift  = shift_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_denorm = denorm_q;
endmodule

// File: tb/tb_fp_norm_seq.sv
// Directed bench for fp_norm_seq: closed-form result model plus literal pins.
module tb_fp_norm_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;

  fp_norm_if #(.MW(24), .EW(8)) bus ();

  fp_norm_seq #(.MW(24), .EW(8), .STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (abort),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  exp;
    int          shift;
    bit          zero;
    bit          denorm;
    int          lat;
  } res_t;

  res_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  // Closed form: total shift is the leading-zero count unless the exponent
  // would hit 1 first, in which case the result floors to a denormal.
  function automatic res_t model(input logic [23:0] m, input logic [7:0] e);
    res_t r;
    int   lz, ei, s;
    ei = int'(e);
    r.zero = 0;
    r.denorm = 0;
    if (m == 24'd0) begin
      r.mant = '0; r.exp = '0; r.shift = 0; r.zero = 1; r.lat = 1;
      return r;
    end
    lz = 24 - $clog2(int'(m) + 1);
    if (ei == 0) begin
      s = 0; r.exp = '0; r.denorm = 1;
    end else if (lz <= ei - 1) begin
      s = lz; r.exp = 8'(ei - lz);
    end else begin
      s = ei - 1; r.exp = '0; r.denorm = 1;
    end
    r.mant  = m << s;
    r.shift = s;
    r.lat   = (s + 3) / 4 + 1;
    return r;
  endfunction

  int cyc = 0;
  bit prev_ov = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_vs_busy", {31'd0, bus.in_ready}, {31'd0, !busy});
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          chk("m_mant",   {8'd0, bus.out_mant}, {8'd0, exp_q[0].mant});
          chk("m_exp",    {24'd0, bus.out_exp}, {24'd0, exp_q[0].exp});
          chk("m_shift",  {27'd0, bus.out_shift}, 32'(exp_q[0].shift));
          chk("m_zero",   {31'd0, bus.out_zero}, {31'd0, exp_q[0].zero});
          chk("m_denorm", {31'd0, bus.out_denorm}, {31'd0, exp_q[0].denorm});
          if (!prev_ov) chk("m_latency", 32'(cyc), 32'(exp_q[0].lat));
        end
      end
      prev_ov = bus.out_valid;
      cyc++;
      if (bus.in_valid && bus.in_ready) cyc = 0;
      if (bus.out_valid && bus.out_ready && !abort && exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      prev_ov = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the result handshake.
  task automatic run_op(input logic [23:0] m, input logic [7:0] e, input int hold,
                        input bit lit, input logic [23:0] l_mant, input logic [7:0] l_exp,
                        input int l_shift, input bit l_zero, input bit l_denorm, input int l_lat);
    int n;
    exp_q.push_back(model(m, e));
    bus.in_valid = 1'b1;
    bus.in_mant  = m;
    bus.in_exp   = e;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      chk("result_timeout", 32'd1, 32'd0);
      return;
    end
    if (lit) begin
      chk("lit_latency", 32'(n), 32'(l_lat));
      chk("lit_mant",    {8'd0, bus.out_mant}, {8'd0, l_mant});
      chk("lit_exp",     {24'd0, bus.out_exp}, {24'd0, l_exp});
      chk("lit_shift",   {27'd0, bus.out_shift}, 32'(l_shift));
      chk("lit_zero",    {31'd0, bus.out_zero}, {31'd0, l_zero});
      chk("lit_denorm",  {31'd0, bus.out_denorm}, {31'd0, l_denorm});
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("ready_after_hs", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mant",   {8'd0, bus.out_mant}, 32'd0);
    chk("rst_exp",    {24'd0, bus.out_exp}, 32'd0);
    chk("rst_shift",  {27'd0, bus.out_shift}, 32'd0);
    chk("rst_zero",   {31'd0, bus.out_zero}, 32'd0);
    chk("rst_denorm", {31'd0, bus.out_denorm}, 32'd0);
    chk("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    run_op(24'h000F00,  8'd50, 0, 1, 24'hF00000, 8'd38, 12, 0, 0, 4);
    run_op(24'h800001, 8'd127, 0, 1, 24'h800001, 8'd127, 0, 0, 0, 1);
    run_op(24'h000000,  8'd90, 0, 1, 24'h000000, 8'd0,   0, 1, 0, 1);
    run_op(24'h000100,   8'd5, 0, 1, 24'h001000, 8'd0,   4, 0, 1, 2);
    run_op(24'h00ABCD, 8'd200, 5, 0, 24'h0, 8'd0, 0, 0, 0, 0);
    run_op(24'h7FFFFF,   8'd2, 0, 1, 24'hFFFFFE, 8'd1,   1, 0, 0, 2);
    run_op(24'h400000,   8'd0, 0, 1, 24'h400000, 8'd0,   0, 0, 1, 1);
    run_op(24'h000001,  8'd10, 0, 1, 24'h000200, 8'd0,   9, 0, 1, 4);
    run_op(24'h800000,   8'd1, 2, 1, 24'h800000, 8'd1,   0, 0, 0, 1);

    // Abort mid-SHIFT: nothing pushed to the model, so any out_valid is flagged.
    bus.in_valid = 1'b1;
    bus.in_mant  = 24'h000001;
    bus.in_exp   = 8'd100;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy",  {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (8) begin
      @(posedge clk); #1;
      chk("abort_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    // Asynchronous reset in the middle of a SHIFT sequence.
    bus.in_valid = 1'b1;
    bus.in_mant  = 24'h000001;
    bus.in_exp   = 8'd100;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_mant", {8'd0, bus.out_mant}, 32'h000010);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_mant",   {8'd0, bus.out_mant}, 32'd0);
    chk("arst_exp",    {24'd0, bus.out_exp}, 32'd0);
    chk("arst_shift",  {27'd0, bus.out_shift}, 32'd0);
    chk("arst_zero",   {31'd0, bus.out_zero}, 32'd0);
    chk("arst_denorm", {31'd0, bus.out_denorm}, 32'd0);
    chk("arst_valid",  {31'd0, bus.out_valid}, 32'd0);
    chk("arst_busy",   {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(24'h000F00, 8'd50, 0, 1, 24'hF00000, 8'd38, 12, 0, 0, 4);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_norm_seq.md
Name: fp_norm_seq

Overview:
- Multi-cycle sequencer for the mantissa normalisation step of the 32-bit FP add/sub datapath.
- Accepts a raw 24-bit sum mantissa and its 8-bit exponent over a valid/ready handshake.
- Left-shifts the mantissa by at most STEP bits per cycle until the hidden bit is set, decrementing the exponent by the same amount.
- Detects zero and denormal results, then presents the result over an output valid/ready handshake. It sits between the add stage and the rounding/pack stage.

Parameters:
MW, 24, mantissa width including hidden bit
EW, 8, exponent width
STEP, 4, maximum left-shift per cycle (1..MW-1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  block can accept operand
in_mant  input  MW  unnormalised mantissa
in_exp  input  EW  exponent of in_mant
abort  input  1  synchronous cancel of current operation
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_mant  output  MW  normalised mantissa
out_exp  output  EW  adjusted exponent
out_shift  output  5  total left shift applied
out_zero  output  1  result is zero
out_denorm  output  1  result is denormal (exponent floored)
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE. out_mant=0, out_exp=0, out_shift=0, out_zero=0, out_denorm=0, out_valid=0, busy=0. in_ready=1 once rst_n deasserts.
- Reset mid-operation discards all state immediately.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state!=IDLE).
- IDLE: on in_valid&&in_ready, capture in_mant/in_exp into working registers, clear out_shift, go to SHIFT.
- SHIFT: one decision per cycle, priority order:
  1. mant==0 -> mant=0, exp=0, out_zero=1, go to DONE.
  2. mant[MW-1]==1 -> go to DONE, values unchanged.
  3. exp<=1 -> exp=0, out_denorm=1, go to DONE. Mantissa keeps its current position.
  4. Otherwise k = min(lzc(mant), STEP, exp-1). Then mant<<=k, exp-=k, out_shift+=k, stay in SHIFT.
- Rule 3 applies to in_exp==0 on the first SHIFT cycle, with no shift.
- The exponent never wraps below 0. The decrement is never larger than exp-1, so there is no underflow.
- Latency: out_valid rises ceil(lz/STEP)+1 cycles after the accept edge, or fewer if rule 1 or 3 terminates early.
- DONE: outputs are held stable while out_ready=0.
- On out_valid&&out_ready, return to IDLE. in_ready goes high the following cycle, so the minimum initiation interval is latency+1.
- out_zero, out_denorm and out_shift are valid only while out_valid=1. They are cleared on the next accept.
- abort=1 in SHIFT or DONE -> IDLE next edge, out_valid drops, and the result is lost. abort in IDLE has no effect. abort has priority over the out handshake in the same cycle.
- in_valid while not in_ready is ignored. The producer must hold its data.

Test Plan:
- STEP=4, in_mant=0x000F00, in_exp=50 -> 3 SHIFT iterations. out_mant=0xF00000, out_exp=38, out_shift=12, zero=0, denorm=0. out_valid 4 cycles after accept.
- in_mant=0x800001, in_exp=127 -> out_valid 1 cycle after accept. Outputs unchanged, out_shift=0.
- in_mant=0x000000, in_exp=90 -> out_valid 1 cycle after accept. out_mant=0, out_exp=0, out_zero=1.
- in_mant=0x000100, in_exp=5 -> first cycle k=4 giving mant=0x001000, exp=1. Second cycle gives out_exp=0, out_mant=0x001000, out_shift=4, out_denorm=1. out_valid 2 cycles after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0. On the out_ready pulse, in_ready=1 on the next cycle and a back-to-back operand is accepted.
- Abort during SHIFT (in_mant=0x000001, in_exp=100) -> IDLE next edge, no out_valid. Asserting rst_n=0 mid-SHIFT clears all outputs asynchronously.
